lc3b_mem_ctrl: RTL and testbench
================================

// Module: lc3b_mem_ctrl
// PURPOSE
// - Memory-side stage for the lc3b multicycle core: serves the control FSM's mem_read/mem_write
//   requests (held until mem_resp) against a single-port synchronous SRAM with programmable wait states.
// - Latches the address, write data and byte enables, sequences the SRAM access and returns exactly one
//   mem_resp pulse per request.
// - Read data is valid during the mem_resp cycle, so MDR captures it on that edge.
// PARAMETERS
// - WAIT_CYCLES  2   extra stall cycles before the SRAM access; 0 allowed (skips WAIT)
// - ADDR_W       16  byte-address width; the SRAM word address is ADDR_W-1 bits
// PORTS
// - clk          in   1         rising-edge clock
// - rst          in   1         asynchronous, active-high reset
// - mem_read     in   1         read request, level, held until mem_resp
// - mem_write    in   1         write request, level, held until mem_resp
// - mem_address  in   ADDR_W    byte address; bit 0 ignored (word access)
// - mem_wdata    in   16        write data
// - mem_byte_enable in 2        write byte mask, [1]=high byte, [0]=low byte
// - mem_rdata    out  16        read data
// - mem_resp     out  1         one-cycle completion pulse
// - mem_err      out  1         error flag, valid with mem_resp (MEM_CTRL_ERR_EN only, else tied 0)
// - sram_en      out  1         SRAM access strobe
// - sram_we      out  1         SRAM write strobe, qualified by sram_en
// - sram_addr    out  ADDR_W-1  SRAM word address = latched mem_address[ADDR_W-1:1]
// - sram_wdata   out  16        SRAM write data
// - sram_be      out  2         SRAM byte mask; 2'b11 on reads
// - sram_rdata   in   16        SRAM read data, valid the cycle after sram_en with sram_we=0
// BEHAVIOUR
// - FSM states: IDLE, WAIT, ACCESS, RESP, RECOVER. Reset state: IDLE.
// - Reset (async, any state): state=IDLE; wait counter=0; rdata_q=16'h0000; all outputs 0.
// - IDLE:
//   - Request accepted when mem_read|mem_write=1.
//   - Latches addr, wdata, byte_enable and op; write wins if both are high (no macro).
//   - Loads counter=WAIT_CYCLES and goes to WAIT, or to ACCESS if WAIT_CYCLES=0.
// - WAIT: counter decrements each cycle; on the cycle counter==1, next state is ACCESS.
// - ACCESS (exactly 1 cycle):
//   - sram_en=1, sram_addr from the latched address.
//   - Write: sram_we=1, sram_wdata and sram_be from the latched values.
//   - Read: sram_we=0, sram_be=2'b11.
// - RESP (exactly 1 cycle):
//   - mem_resp=1.
//   - Read: mem_rdata=sram_rdata (combinational pass-through); rdata_q<=sram_rdata at the edge.
//   - Write: SRAM is not accessed; mem_rdata=rdata_q.
// - RECOVER (1 cycle): mem_resp=0; requests ignored, so a request still high after the pulse cannot
//   start a second access. Then IDLE.
// - Outside RESP, mem_rdata=rdata_q (last read value held).
// - Latency: request first seen in IDLE at cycle T gives mem_resp at T+WAIT_CYCLES+2.
//   Back-to-back minimum spacing is WAIT_CYCLES+4 cycles.
// - Request dropped mid-transaction: the access still completes and mem_resp still pulses.
//   Inputs are not re-sampled after IDLE.
// - Address wrap: none; sram_addr is a truncated word index.
// - Reset mid-transaction: sram_en and mem_resp drop immediately; any write in ACCESS is abandoned.
// CONFIGURATION
// - MEM_CTRL_ERR_EN defined:
//   - mem_read&mem_write both high in IDLE raises an error: no SRAM access (sram_en stays 0).
//   - FSM goes IDLE->RESP directly: mem_resp=1 and mem_err=1 for one cycle, mem_rdata=rdata_q, then RECOVER.
//   - mem_err=0 on all normal responses.
// - MEM_CTRL_ERR_EN undefined: mem_err tied 0; simultaneous read and write is treated as a write.
// TESTING
// - WAIT_CYCLES=2, preload word 0x0010=16'hBEEF; read addr 16'h0020, held -> sram_en at T+3
//   with sram_addr=15'h0010; mem_resp at T+4 with mem_rdata=16'hBEEF; resp high exactly 1 cycle.
// - Write addr 16'h0020, wdata 16'h1234, be 2'b01 -> sram_we=1, sram_be=2'b01 in ACCESS.
//   Read back -> 16'hBE34.
// - Request held high through RECOVER -> exactly one sram_en pulse and one mem_resp per request.
//   Fresh request after IDLE -> next mem_resp spaced 6 cycles from the first.
// - WAIT_CYCLES=0: read accepted at T -> ACCESS at T+1, mem_resp at T+2.
// - Assert rst during WAIT -> all outputs 0 at once; no sram_en and no mem_resp.
//   After release, a new read completes normally.
// - MEM_CTRL_ERR_EN, read&write together -> mem_resp=mem_err=1 at T+1, sram_en never asserted.
//   Without the macro -> behaves as a write.

Source files
------------

// File: rtl/lc3b_mem_ctrl_if.sv
// lc3b_mem_ctrl_if: core-side request bus and SRAM-side bus of the lc3b memory stage.
//   slave modport  : memory controller (takes mem_* requests, drives sram_* strobes)
//   master modport : requester and SRAM side (drives mem_* requests and sram_rdata)
//   mem_read/mem_write level requests, mem_address byte address, mem_wdata, mem_byte_enable
//   mem_rdata/mem_resp/mem_err completion, sram_en/we/addr/wdata/be access, sram_rdata read data
interface lc3b_mem_ctrl_if #(parameter int ADDR_W = 16);
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [15:0]       mem_wdata;
  logic [1:0]        mem_byte_enable;
  logic [15:0]       mem_rdata;
  logic              mem_resp;
  logic              mem_err;
  logic              sram_en;
  logic              sram_we;
  logic [ADDR_W-2:0] sram_addr;
  logic [15:0]       sram_wdata;
  logic [1:0]        sram_be;
  logic [15:0]       sram_rdata;
  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable, sram_rdata,
    output mem_rdata, mem_resp, mem_err, sram_en, sram_we, sram_addr, sram_wdata, sram_be
  );
  modport master (
    output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable, sram_rdata,
    input  mem_rdata, mem_resp, mem_err, sram_en, sram_we, sram_addr, sram_wdata, sram_be
  );
endinterface

// File: rtl/lc3b_mem_ctrl.sv
// lc3b_mem_ctrl: memory stage serving held mem_read/mem_write requests against a wait-stated sync SRAM.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  lc3b_mem_ctrl_if.slave: mem_* request/response side and sram_* access side
//   WAIT_CYCLES stall cycles before the SRAM access (0 skips WAIT), ADDR_W byte-address width
//   Optional macro MEM_CTRL_ERR_EN: simultaneous read and write answers with mem_err and no SRAM access;
//   when undefined mem_err is tied 0 and read+write is treated as a write.
module lc3b_mem_ctrl #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 16
) (
  input logic              clk,
  input logic              rst,
  lc3b_mem_ctrl_if.slave   bus
);
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  typedef enum logic [2:0] {IDLE, WAIT, ACCESS, RESP, RECOVER} state_t;
  state_t            r_state, w_next;
  logic [CW-1:0]     r_cnt;
  logic [ADDR_W-2:0] r_addr;
  logic [15:0]       r_wdata, r_rdata;
  logic [1:0]        r_be;
  logic              r_we, r_err;
  logic              w_req, w_err, w_acc, w_resp, w_rd_resp;
  assign w_req = bus.mem_read | bus.mem_write;
`ifdef MEM_CTRL_ERR_EN
  assign w_err = bus.mem_read & bus.mem_write;
`else
  assign w_err = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_req) w_next = w_err ? RESP : (WAIT_CYCLES == 0) ? ACCESS : WAIT;
      WAIT:    if (r_cnt == CW'(1)) w_next = ACCESS;
      ACCESS:  w_next = RESP;
      RESP:    w_next = RECOVER;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_req) begin
        r_addr  <= bus.mem_address[ADDR_W-1:1];
        r_wdata <= bus.mem_wdata;
        r_be    <= bus.mem_byte_enable;
        r_we    <= bus.mem_write;
        r_err   <= w_err;
        r_cnt   <= CW'(WAIT_CYCLES);
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_rd_resp) r_rdata <= bus.sram_rdata;
    end
  end
  assign w_acc     = r_state == ACCESS;
  assign w_resp    = r_state == RESP;
  // only a genuine read response forwards SRAM data; writes and errors show the held value
  assign w_rd_resp = w_resp & ~r_we & ~r_err;
  assign bus.sram_en    = w_acc;
  assign bus.sram_we    = w_acc & r_we;
  assign bus.sram_addr  = w_acc ? r_addr : '0;
  assign bus.sram_wdata = (w_acc & r_we) ? r_wdata : '0;
  assign bus.sram_be    = ~w_acc ? 2'b00 : r_we ? r_be : 2'b11;
  assign bus.mem_resp   = w_resp;
  assign bus.mem_err    = w_resp & r_err;
  assign bus.mem_rdata  = w_rd_resp ? bus.sram_rdata : r_rdata;
endmodule

// File: tb/tb_lc3b_mem_ctrl.sv
// tb_lc3b_mem_ctrl: directed bench for lc3b_mem_ctrl (WAIT_CYCLES=2 instance A, WAIT_CYCLES=0 instance B).
module tb_lc3b_mem_ctrl;
  logic clk, rst;
  int total = 0, bad = 0;
  lc3b_mem_ctrl_if #(.ADDR_W(16)) bus_a();
  lc3b_mem_ctrl_if #(.ADDR_W(16)) bus_b();
  lc3b_mem_ctrl #(.WAIT_CYCLES(2), .ADDR_W(16)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  lc3b_mem_ctrl #(.WAIT_CYCLES(0), .ADDR_W(16)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  logic [15:0] mem_a [256];
  logic [15:0] mem_b [256];
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus_a.sram_en) begin
      if (bus_a.sram_we) begin
        if (bus_a.sram_be[0]) mem_a[bus_a.sram_addr[7:0]][7:0] <= bus_a.sram_wdata[7:0];
        if (bus_a.sram_be[1]) mem_a[bus_a.sram_addr[7:0]][15:8] <= bus_a.sram_wdata[15:8];
      end else bus_a.sram_rdata <= mem_a[bus_a.sram_addr[7:0]];
    end
    if (bus_b.sram_en) begin
      if (bus_b.sram_we) begin
        if (bus_b.sram_be[0]) mem_b[bus_b.sram_addr[7:0]][7:0] <= bus_b.sram_wdata[7:0];
        if (bus_b.sram_be[1]) mem_b[bus_b.sram_addr[7:0]][15:8] <= bus_b.sram_wdata[15:8];
      end else bus_b.sram_rdata <= mem_b[bus_b.sram_addr[7:0]];
    end
  end
  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [14:0] exp_addr;
    logic [15:0] exp_rdata;
  } vec_t;
  vec_t tbl [7];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic txn(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] wd,
                     input logic [1:0] be, output int t_en, output int t_resp, output int n_en,
                     output logic [15:0] rdv, output logic err, output logic en_we,
                     output logic [14:0] en_addr, output logic [15:0] en_wd, output logic [1:0] en_be);
    t_en = -1; t_resp = -1; n_en = 0; rdv = '0; err = 1'b0;
    en_we = 1'b0; en_addr = '0; en_wd = '0; en_be = '0;
    bus_a.mem_read = rd; bus_a.mem_write = wr;
    bus_a.mem_address = a; bus_a.mem_wdata = wd; bus_a.mem_byte_enable = be;
    for (int i = 1; i <= 20 && t_resp < 0; i++) begin
      @(negedge clk);
      if (bus_a.sram_en) begin
        n_en++; t_en = i; en_we = bus_a.sram_we; en_addr = bus_a.sram_addr;
        en_wd = bus_a.sram_wdata; en_be = bus_a.sram_be;
      end
      if (bus_a.mem_resp) begin
        t_resp = i; rdv = bus_a.mem_rdata; err = bus_a.mem_err;
      end
    end
    bus_a.mem_read = 1'b0; bus_a.mem_write = 1'b0;
  endtask
  task automatic recover_a(input string nm);
    @(negedge clk);
    chk({nm, " resp_one_cycle"}, 32'(bus_a.mem_resp), 32'd0);
    chk({nm, " recover_no_en"}, 32'(bus_a.sram_en), 32'd0);
    @(negedge clk);
  endtask
  initial begin
    int t_en, t_resp, n_en, r1, r2, n_en5, nr5, nr;
    logic [15:0] rdv, rd2;
    logic err, en_we;
    logic [14:0] en_addr;
    logic [15:0] en_wd;
    logic [1:0] en_be;
    tbl[0] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, 15'h0010, 16'hBEEF};
    tbl[1] = '{1'b0, 1'b1, 16'h0020, 16'h1234, 2'b01, 15'h0010, 16'hBEEF};
    tbl[2] = '{1'b1, 1'b0, 16'h0021, 16'h0000, 2'b00, 15'h0010, 16'hBE34};
    tbl[3] = '{1'b0, 1'b1, 16'h0040, 16'hA5C3, 2'b10, 15'h0020, 16'hBE34};
    tbl[4] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 15'h0020, 16'hA500};
    tbl[5] = '{1'b0, 1'b1, 16'hFFFE, 16'h5A5A, 2'b11, 15'h7FFF, 16'hA500};
    tbl[6] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 2'b00, 15'h7FFF, 16'h5A5A};
    for (int i = 0; i < 256; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
    mem_a[8'h10] = 16'hBEEF;
    mem_b[8'h10] = 16'hCAFE;
    bus_a.mem_read = 0; bus_a.mem_write = 0; bus_a.mem_address = 0;
    bus_a.mem_wdata = 0; bus_a.mem_byte_enable = 0; bus_a.sram_rdata = 0;
    bus_b.mem_read = 0; bus_b.mem_write = 0; bus_b.mem_address = 0;
    bus_b.mem_wdata = 0; bus_b.mem_byte_enable = 0; bus_b.sram_rdata = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset sram_en", 32'(bus_a.sram_en), 32'd0);
    chk("reset mem_resp", 32'(bus_a.mem_resp), 32'd0);
    chk("reset mem_rdata", 32'(bus_a.mem_rdata), 32'd0);
    chk("reset sram_be", 32'(bus_a.sram_be), 32'd0);
    chk("reset b resp", 32'(bus_b.mem_resp), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 7; k++) begin
      txn(tbl[k].rd, tbl[k].wr, tbl[k].addr, tbl[k].wdata, tbl[k].be,
          t_en, t_resp, n_en, rdv, err, en_we, en_addr, en_wd, en_be);
      chk($sformatf("v%0d en_time", k), 32'(t_en), 32'd3);
      chk($sformatf("v%0d resp_time", k), 32'(t_resp), 32'd4);
      chk($sformatf("v%0d en_count", k), 32'(n_en), 32'd1);
      chk($sformatf("v%0d sram_addr", k), 32'(en_addr), 32'(tbl[k].exp_addr));
      chk($sformatf("v%0d sram_we", k), 32'(en_we), 32'(tbl[k].wr));
      chk($sformatf("v%0d sram_be", k), 32'(en_be), tbl[k].wr ? 32'(tbl[k].be) : 32'd3);
      if (tbl[k].wr) chk($sformatf("v%0d sram_wdata", k), 32'(en_wd), 32'(tbl[k].wdata));
      chk($sformatf("v%0d mem_rdata", k), 32'(rdv), 32'(tbl[k].exp_rdata));
      chk($sformatf("v%0d mem_err", k), 32'(err), 32'd0);
      recover_a($sformatf("v%0d", k));
    end
    // request held through RECOVER: one access per request, second response 6 cycles later
    bus_a.mem_read = 1'b1; bus_a.mem_address = 16'h0020;
    r1 = -1; r2 = -1; n_en = 0; nr = 0; n_en5 = -1; nr5 = -1; rd2 = '0;
    for (int i = 1; i <= 16 && r2 < 0; i++) begin
      @(negedge clk);
      if (bus_a.sram_en) n_en++;
      if (bus_a.mem_resp) begin
        nr++;
        if (r1 < 0) r1 = i; else begin r2 = i; rd2 = bus_a.mem_rdata; end
      end
      if (i == 5) begin n_en5 = n_en; nr5 = nr; end
    end
    bus_a.mem_read = 1'b0;
    chk("hold first resp", 32'(r1), 32'd4);
    chk("hold en through recover", 32'(n_en5), 32'd1);
    chk("hold resp through recover", 32'(nr5), 32'd1);
    chk("hold second resp", 32'(r2), 32'd10);
    chk("hold total en", 32'(n_en), 32'd2);
    chk("hold second rdata", 32'(rd2), 32'hBE34);
    recover_a("hold");
    // request dropped after acceptance still completes
    bus_a.mem_read = 1'b1; bus_a.mem_address = 16'h0040;
    r1 = -1; n_en = 0; rdv = '0;
    for (int i = 1; i <= 10 && r1 < 0; i++) begin
      @(negedge clk);
      bus_a.mem_read = 1'b0;
      if (bus_a.sram_en) n_en++;
      if (bus_a.mem_resp) begin r1 = i; rdv = bus_a.mem_rdata; end
    end
    chk("drop resp_time", 32'(r1), 32'd4);
    chk("drop en_count", 32'(n_en), 32'd1);
    chk("drop rdata", 32'(rdv), 32'hA500);
    recover_a("drop");
    // reset asserted during WAIT
    bus_a.mem_read = 1'b1; bus_a.mem_address = 16'h0020;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst sram_en", 32'(bus_a.sram_en), 32'd0);
    chk("rst sram_we", 32'(bus_a.sram_we), 32'd0);
    chk("rst sram_addr", 32'(bus_a.sram_addr), 32'd0);
    chk("rst sram_be", 32'(bus_a.sram_be), 32'd0);
    chk("rst mem_resp", 32'(bus_a.mem_resp), 32'd0);
    chk("rst mem_rdata", 32'(bus_a.mem_rdata), 32'd0);
    bus_a.mem_read = 1'b0;
    n_en = 0; nr = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 2) rst = 1'b0;
      if (bus_a.sram_en) n_en++;
      if (bus_a.mem_resp) nr++;
    end
    chk("rst no en", 32'(n_en), 32'd0);
    chk("rst no resp", 32'(nr), 32'd0);
    txn(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, t_en, t_resp, n_en, rdv, err, en_we, en_addr, en_wd, en_be);
    chk("post_rst resp_time", 32'(t_resp), 32'd4);
    chk("post_rst rdata", 32'(rdv), 32'hBE34);
    recover_a("post_rst");
    // zero wait states on instance B
    bus_b.mem_read = 1'b1; bus_b.mem_address = 16'h0020;
    r1 = -1; r2 = -1; n_en = 0; rdv = '0; en_addr = '0;
    for (int i = 1; i <= 8 && r2 < 0; i++) begin
      @(negedge clk);
      if (bus_b.sram_en) begin n_en++; r1 = i; en_addr = bus_b.sram_addr; end
      if (bus_b.mem_resp) begin r2 = i; rdv = bus_b.mem_rdata; end
    end
    bus_b.mem_read = 1'b0;
    chk("w0 en_time", 32'(r1), 32'd1);
    chk("w0 sram_addr", 32'(en_addr), 32'h10);
    chk("w0 resp_time", 32'(r2), 32'd2);
    chk("w0 rdata", 32'(rdv), 32'hCAFE);
    @(negedge clk);
    chk("w0 resp_one_cycle", 32'(bus_b.mem_resp), 32'd0);
    @(negedge clk);
`ifdef MEM_CTRL_ERR_EN
    bus_a.mem_read = 1'b1; bus_a.mem_write = 1'b1; bus_a.mem_address = 16'h0020;
    bus_a.mem_wdata = 16'h7777; bus_a.mem_byte_enable = 2'b11;
    r1 = -1; n_en = 0; nr = 0; err = 1'b0; rdv = '0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (bus_a.sram_en) n_en++;
      if (bus_a.mem_resp) begin
        nr++; r1 = i; err = bus_a.mem_err; rdv = bus_a.mem_rdata;
        bus_a.mem_read = 1'b0; bus_a.mem_write = 1'b0;
      end
    end
    chk("err resp_time", 32'(r1), 32'd1);
    chk("err flag", 32'(err), 32'd1);
    chk("err resp_count", 32'(nr), 32'd1);
    chk("err no en", 32'(n_en), 32'd0);
    chk("err rdata", 32'(rdv), 32'hBE34);
    txn(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, t_en, t_resp, n_en, rdv, err, en_we, en_addr, en_wd, en_be);
    chk("err readback", 32'(rdv), 32'hBE34);
    recover_a("err_rb");
`else
    txn(1'b1, 1'b1, 16'h0020, 16'h7777, 2'b11, t_en, t_resp, n_en, rdv, err, en_we, en_addr, en_wd, en_be);
    chk("rw resp_time", 32'(t_resp), 32'd4);
    chk("rw sram_we", 32'(en_we), 32'd1);
    chk("rw sram_be", 32'(en_be), 32'd3);
    chk("rw mem_err", 32'(err), 32'd0);
    recover_a("rw");
    txn(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, t_en, t_resp, n_en, rdv, err, en_we, en_addr, en_wd, en_be);
    chk("rw readback", 32'(rdv), 32'h7777);
    recover_a("rw_rb");
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
